even_parity_seq_ctrl: RTL and testbench
=======================================

// Module: even_parity_seq_ctrl
//
// PURPOSE
//   Bit-serial sequencer for the even-parity check path. Accepts one DATA_W-bit
//   word plus its even-parity bit over a valid/ready handshake and folds the
//   word into a running XOR one bit per cycle. It returns the check result over
//   a second valid/ready handshake and keeps a saturating error count.
//   It sits between a word producer and any consumer of parity-check status.
//
// PARAMETERS
//   DATA_W   3   data word width in bits (>= 1)
//   CNT_W    8   error-counter width in bits (>= 1)
//
// PORTS
//   clk        in   1        single clock; all state updates on its rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        producer has a word on in_data/in_p
//   in_ready   out  1        block can accept a word (high only in IDLE)
//   in_data    in   DATA_W   data word
//   in_p       in   1        even-parity bit supplied with the word
//   out_valid  out  1        check result available (high only in RESULT)
//   out_ready  in   1        consumer takes the result
//   out_pc     out  1        parity-check result: XOR of all data bits and p; 1 = error
//   busy       out  1        high in SHIFT or RESULT
//   clr_cnt    in   1        synchronous clear of err_cnt
//   err_cnt    out  CNT_W    saturating count of delivered results with out_pc=1
//
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; out_pc=0; busy=0;
//     err_cnt=0; the shift register, accumulator and bit index are cleared.
//   FSM states: IDLE, SHIFT, RESULT.
//   - IDLE: in_ready=1. On the in_valid&in_ready edge: capture in_data into the
//     shift register, set acc=in_p, set idx=0, and go to SHIFT.
//   - SHIFT: each cycle acc ^= shreg[0], shreg >>= 1 (LSB first), idx++. When idx
//     reaches DATA_W-1 on an edge, go to RESULT. SHIFT lasts exactly DATA_W cycles.
//   - RESULT: out_valid=1; out_pc=acc, held stable. On the out_valid&out_ready edge,
//     go to IDLE.
//   Latency: out_valid rises DATA_W cycles after the input-accept edge.
//     Minimum word period is DATA_W+2 cycles, with a mandatory one-cycle IDLE bubble.
//     No input is accepted on the edge where the result is taken.
//   Backpressure: RESULT holds out_valid and out_pc indefinitely while out_ready=0.
//   in_data and in_p are sampled only on the accept edge; later changes are ignored.
//   err_cnt:
//     - increments by 1 on the output handshake edge when out_pc=1;
//     - saturates at 2^CNT_W-1 with no wrap;
//     - clr_cnt=1 forces 0 and wins over a same-cycle increment;
//     - clr_cnt is legal in any state and does not disturb the FSM.
//   Reset mid-operation (SHIFT or RESULT): the word is discarded and not counted.
//     After rst_n is released, the FSM returns to IDLE.
//   out_pc is 0 whenever out_valid=0.
//   idx width is $clog2(DATA_W), minimum 1 bit. For DATA_W=1, SHIFT lasts one cycle.
//
// STRUCTURE
//   Shared package even_parity_pkg:
//     - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_RESULT=2'd2;
//     - a function for the saturating increment.
//   Sub-module parity_acc:
//     - holds the shift register, XOR accumulator and bit index;
//     - ports load, step, data, p_in, acc, last.
//   Top level: FSM, handshakes and error counter.
//
// TESTING (DATA_W=3, CNT_W=8 unless stated)
//   1. Accept i=000,p=1, out_ready=1 -> out_valid 3 cycles after accept, out_pc=1, err_cnt=1.
//   2. Sequence (001,1),(101,0),(111,0),(110,1), out_ready=1 -> out_pc=0,0,1,1;
//      err_cnt ends at 2; every word period is 5 cycles.
//   3. Backpressure: out_ready=0 for 10 cycles in RESULT -> out_valid and out_pc stable,
//      in_ready=0; after out_ready=1 there is one IDLE cycle before the next accept.
//   4. CNT_W=2: deliver 5 error words -> err_cnt sequence 1,2,3,3,3; then clr_cnt
//      asserted in the same cycle as an error handshake -> err_cnt=0.
//   5. Assert rst_n=0 at the second SHIFT cycle -> immediate IDLE, out_valid=0,
//      err_cnt=0; the next word 011,p=0 gives out_pc=0.
//   6. Change in_data and in_p during SHIFT -> result reflects only the value captured
//      at the accept edge.

Source files
------------

// File: rtl/even_parity_pkg.sv
// Shared state encoding and counter helper for the even-parity sequencer.
package even_parity_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  // Holds at max instead of wrapping; callers zero-extend to 32 bits and truncate back.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt == max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// Shift register, XOR accumulator and bit index for LSB-first parity folding.
// load has priority over step; last flags the final bit of the word.
module parity_acc #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  input  logic              p_in,
  output logic              acc,
  output logic              last
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shreg_q;
  logic              acc_q;
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      acc_q   <= 1'b0;
      idx_q   <= '0;
    end else if (load) begin
      shreg_q <= data;
      acc_q   <= p_in;
      idx_q   <= '0;
    end else if (step) begin
      shreg_q <= shreg_q >> 1;
      acc_q   <= acc_q ^ shreg_q[0];
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

  assign acc  = acc_q;
  assign last = (idx_q == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/even_parity_seq_ctrl.sv
// Bit-serial even-parity checker: result valid DATA_W cycles after accept, word period DATA_W+2.
// RESULT holds out_valid/out_pc while out_ready=0; input is refused until the result drains.
module even_parity_seq_ctrl
  import even_parity_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_pc,
  output logic              busy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             load, step, acc, last;

  parity_acc #(.DATA_W(DATA_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .data  (in_data),
    .p_in  (in_p),
    .acc   (acc),
    .last  (last)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESULT);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_RESULT);
  assign out_pc    = out_valid & acc;
  assign load      = in_ready & in_valid;
  assign step      = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT:  if (last)      state_d = ST_RESULT;
      ST_RESULT: if (out_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Clear beats a same-cycle increment so software sees a clean zero.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (out_valid && out_ready && out_pc) begin
      err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), 32'({CNT_W{1'b1}})));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_even_parity_seq_ctrl.sv
// Directed bench for even_parity_seq_ctrl (DATA_W=3) with a second CNT_W=2 instance for saturation.
module tb_even_parity_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = 3'd0;
  logic       in_p = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       in_ready, out_valid, out_pc, busy;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, out_pc2, busy2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  even_parity_seq_ctrl #(.DATA_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .busy(busy), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  even_parity_seq_ctrl #(.DATA_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_p(in_p), .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .busy(busy2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents a word and returns once it is accepted (ok=0 if never accepted).
  task automatic send(input logic [2:0] d, input logic p, output int acc_cyc, output bit ok);
    in_data = d;
    in_p = p;
    in_valid = 1'b1;
    ok = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // Counts edges after accept until out_valid is seen (returns -1 on timeout).
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 1'b0) begin errors++; $display("FAIL reset_out_pc got %b want 0", out_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    int t, lat;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    send(3'b000, 1'b1, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout want accept"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL single_shift_flags got busy=%b in_ready=%b want 1 0", busy, in_ready); end
    wait_valid(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
    checks++; if (out_pc !== 1'b1) begin errors++; $display("FAIL single_out_pc got %b want 1", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd1) begin errors++; $display("FAIL single_after got out_valid=%b err_cnt=%0d want 0 1", out_valid, err_cnt); end
  endtask

  task automatic test_sequence();
    logic [2:0] d [4] = '{3'b001, 3'b101, 3'b111, 3'b110};
    logic       p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int t, prev_t, lat;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    prev_t = -1;
    for (int k = 0; k < 4; k++) begin
      send(d[k], p[k], t, ok);
      if (k > 0) begin
        checks++; if (t - prev_t !== 5) begin errors++; $display("FAIL seq_period[%0d] got %0d want 5", k, t - prev_t); end
      end
      prev_t = t;
      wait_valid(lat);
      checks++; if (out_pc !== e[k] || lat !== 3) begin errors++; $display("FAIL seq_out_pc[%0d] got pc=%b lat=%0d want pc=%b lat=3", k, out_pc, lat, e[k]); end
      tick();
    end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL seq_err_cnt got %0d want 2", err_cnt); end
  endtask

  task automatic test_backpressure();
    int t, lat;
    bit ok;
    int bad = 0;
    do_reset();
    out_ready = 1'b0;
    send(3'b000, 1'b1, t, ok);
    wait_valid(lat);
    in_data = 3'b111;
    in_p = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_pc !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_bubble got out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bp_err_cnt got %0d want 1", err_cnt); end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b want 1", busy); end
    wait_valid(lat);
    checks++; if (out_pc !== 1'b1) begin errors++; $display("FAIL bp_next_pc got %b want 1", out_pc); end
    tick();
  endtask

  task automatic test_saturate();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int t, lat;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(3'b010, 1'b0, t, ok);
      wait_valid(lat);
      tick();
      checks++; if (err_cnt2 !== exp2[k] || err_cnt !== 8'(k + 1)) begin errors++; $display("FAIL sat_cnt[%0d] got cnt2=%0d cnt8=%0d want %0d %0d", k, err_cnt2, err_cnt, exp2[k], k + 1); end
    end
    send(3'b010, 1'b0, t, ok);
    wait_valid(lat);
    checks++; if (out_pc2 !== 1'b1 || out_valid2 !== 1'b1) begin errors++; $display("FAIL sat_out_pc2 got pc=%b vld=%b want 1 1", out_pc2, out_valid2); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr got cnt2=%0d cnt8=%0d want 0 0", err_cnt2, err_cnt); end
  endtask

  task automatic test_mid_reset();
    int t, lat;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    send(3'b000, 1'b1, t, ok);
    wait_valid(lat);
    tick();
    send(3'b000, 1'b1, t, ok);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    send(3'b011, 1'b0, t, ok);
    wait_valid(lat);
    checks++; if (out_pc !== 1'b0 || lat !== 3) begin errors++; $display("FAIL midrst_next got pc=%b lat=%0d want 0 3", out_pc, lat); end
    tick();
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt_after got %0d want 0", err_cnt); end
  endtask

  task automatic test_sample_hold();
    int t, lat;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    send(3'b100, 1'b0, t, ok);
    in_data = 3'b111;
    in_p = 1'b1;
    wait_valid(lat);
    checks++; if (out_pc !== 1'b1) begin errors++; $display("FAIL hold_out_pc got %b want 1", out_pc); end
    tick();
    send(3'b101, 1'b1, t, ok);
    in_data = 3'b001;
    in_p = 1'b0;
    wait_valid(lat);
    checks++; if (out_pc !== 1'b1) begin errors++; $display("FAIL hold_out_pc2 got %b want 1", out_pc); end
    tick();
    checks++; if (out_pc !== 1'b0) begin errors++; $display("FAIL hold_pc_idle got %b want 0", out_pc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_backpressure();
    test_saturate();
    test_mid_reset();
    test_sample_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
